// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key debouncer signal bundle: raw active-low keys in, clean level and event pulses out
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] long_press;

    // master drives the raw buttons and consumes the debounced events
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  long_press
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output long_press
    );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser and debounce FSM with press/release pulses
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 25000000
) (
    input logic          clk,
    input logic          rst_n,
    key_debounce_if.slave kb
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PDB  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_RDB  = 2'd3;

    if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > 16777215 || LONG_CYC < 2) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYC or LONG_CYC out of range");
    end

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;
    logic [NUM_KEYS-1:0] long_vec;

    // Idle-high reset so a key already held at reset release is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= kb.key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d;
        logic          prs_q, prs_d;
        logic          rel_q, rel_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            prs_d   = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    lvl_d = 1'b0;
                    if (!sync2_q[k]) begin
                        state_d = ST_PDB;
                        cnt_d   = '0;
                    end
                end
                ST_PDB: begin
                    if (sync2_q[k]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        prs_d   = 1'b1;
                        lvl_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    lvl_d = 1'b1;
                    if (sync2_q[k]) begin
                        state_d = ST_RDB;
                        cnt_d   = '0;
                    end
                end
                ST_RDB: begin
                    if (!sync2_q[k]) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                        lvl_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    lvl_d   = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                prs_q   <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                prs_q   <= prs_d;
                rel_q   <= rel_d;
            end
        end

        assign level_vec[k]   = lvl_q;
        assign press_vec[k]   = prs_q;
        assign release_vec[k] = rel_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CYC);
        localparam logic [LW-1:0] LG_MAX = LW'(LONG_CYC - 1);

        logic [LW-1:0] hcnt_q, hcnt_d;
        logic          fired_q, fired_d;
        logic          lng_q, lng_d;

        // Hold time keeps running through release debounce so chatter does not restart it.
        always_comb begin
            hcnt_d  = hcnt_q;
            fired_d = fired_q;
            lng_d   = 1'b0;
            if (state_q == ST_PDB && state_d == ST_HELD) begin
                hcnt_d  = '0;
                fired_d = 1'b0;
            end else if (state_q == ST_HELD || state_q == ST_RDB) begin
                if (hcnt_q == LG_MAX) begin
                    if (!fired_q) begin
                        lng_d   = 1'b1;
                        fired_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hcnt_q  <= '0;
                fired_q <= 1'b0;
                lng_q   <= 1'b0;
            end else begin
                hcnt_q  <= hcnt_d;
                fired_q <= fired_d;
                lng_q   <= lng_d;
            end
        end

        assign long_vec[k] = lng_q;
`else
        assign long_vec[k] = 1'b0;
`endif
    end

    assign kb.key_level   = level_vec;
    assign kb.key_press   = press_vec;
    assign kb.key_release = release_vec;
    assign kb.long_press  = long_vec;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce (DEBOUNCE_CYC=8, LONG_CYC=40)
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   press_cnt [4];
    int   release_cnt [4];
    int   long_cnt [4];
    int   base;
    int   exp_long;

    key_debounce_if #(.NUM_KEYS(4)) kb ();

    key_debounce #(
        .NUM_KEYS    (4),
        .DEBOUNCE_CYC(8),
        .LONG_CYC    (40)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kb   (kb)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            press_cnt[k]   = 0;
            release_cnt[k] = 0;
            long_cnt[k]    = 0;
        end
    end

    // Event tallies plus per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                press_cnt[k]   += int'(kb.key_press[k]);
                release_cnt[k] += int'(kb.key_release[k]);
                long_cnt[k]    += int'(kb.long_press[k]);
            end
            chk("pulse_exclusive", kb.key_press & kb.key_release, 4'b0000);
`ifndef KEY_LONG_PRESS_EN
            chk("long_tied_low", kb.long_press, 4'b0000);
`endif
        end
    end

    initial begin
        rst_n     = 1'b0;
        kb.key_in = 4'b1111;
        ticks(3);
        chk("rst_level", kb.key_level, 4'b0000);
        chk("rst_press", kb.key_press, 4'b0000);
        chk("rst_release", kb.key_release, 4'b0000);
        chk("rst_long", kb.long_press, 4'b0000);
        rst_n = 1'b1;
        ticks(3);
        chk("idle_level", kb.key_level, 4'b0000);

        // clean press and release on key 0
        kb.key_in = 4'b1110;
        ticks(10);
        chk("press0_early", kb.key_press, 4'b0000);
        chk("press0_level_early", kb.key_level, 4'b0000);
        ticks(1);
        chk("press0_pulse", kb.key_press, 4'b0001);
        chk("press0_level", kb.key_level, 4'b0001);
        ticks(1);
        chk("press0_one_cycle", kb.key_press, 4'b0000);
        chk("press0_level_hold", kb.key_level, 4'b0001);
        kb.key_in = 4'b1111;
        ticks(10);
        chk("rel0_early", kb.key_release, 4'b0000);
        chk("rel0_level_early", kb.key_level, 4'b0001);
        ticks(1);
        chk("rel0_pulse", kb.key_release, 4'b0001);
        chk("rel0_level", kb.key_level, 4'b0000);
        ticks(1);
        chk("rel0_one_cycle", kb.key_release, 4'b0000);

        // bounce rejection on key 1
        base = press_cnt[1];
        kb.key_in = 4'b1101; ticks(5);
        kb.key_in = 4'b1111; ticks(2);
        kb.key_in = 4'b1101; ticks(6);
        kb.key_in = 4'b1111; ticks(15);
        chk_int("bounce_no_press", press_cnt[1] - base, 0);
        chk("bounce_level", kb.key_level, 4'b0000);
        kb.key_in = 4'b1101;
        ticks(10);
        chk("press1_early", kb.key_press, 4'b0000);
        ticks(1);
        chk("press1_pulse", kb.key_press, 4'b0010);
        chk("press1_level", kb.key_level, 4'b0010);
        ticks(9);
        chk_int("press1_single", press_cnt[1] - base, 1);
        kb.key_in = 4'b1111;
        ticks(14);
        chk("press1_released", kb.key_level, 4'b0000);

        // release chatter on key 0
        kb.key_in = 4'b1110;
        ticks(12);
        chk("chat_held", kb.key_level, 4'b0001);
        base = release_cnt[0];
        kb.key_in = 4'b1111; ticks(3);
        kb.key_in = 4'b1110; ticks(1);
        kb.key_in = 4'b1111;
        ticks(10);
        chk("chat_rel_early", kb.key_release, 4'b0000);
        chk("chat_level_early", kb.key_level, 4'b0001);
        ticks(1);
        chk("chat_rel_pulse", kb.key_release, 4'b0001);
        chk("chat_level_drop", kb.key_level, 4'b0000);
        ticks(5);
        chk_int("chat_rel_single", release_cnt[0] - base, 1);

        // all keys together
        kb.key_in = 4'b0000;
        ticks(10);
        chk("all_press_early", kb.key_press, 4'b0000);
        ticks(1);
        chk("all_press", kb.key_press, 4'b1111);
        chk("all_level", kb.key_level, 4'b1111);
        ticks(1);
        chk("all_press_one", kb.key_press, 4'b0000);
        kb.key_in = 4'b1111;
        ticks(11);
        chk("all_release", kb.key_release, 4'b1111);
        chk("all_level_drop", kb.key_level, 4'b0000);
        ticks(1);
        chk("all_release_one", kb.key_release, 4'b0000);

        // reset while key 2 is mid press-debounce (counter = 4)
        kb.key_in = 4'b1011;
        ticks(7);
        chk("mid_pdb_press", kb.key_press, 4'b0000);
        chk("mid_pdb_level", kb.key_level, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", kb.key_level, 4'b0000);
        chk("mid_rst_press", kb.key_press, 4'b0000);
        ticks(2);
        chk("mid_rst_level2", kb.key_level, 4'b0000);
        rst_n = 1'b1;
        ticks(10);
        chk("post_rst_early", kb.key_press, 4'b0000);
        ticks(1);
        chk("post_rst_press", kb.key_press, 4'b0100);
        chk("post_rst_level", kb.key_level, 4'b0100);
        kb.key_in = 4'b1111;
        ticks(14);
        chk("post_rst_released", kb.key_level, 4'b0000);

        // 100-cycle hold on key 3
        base = long_cnt[3];
        kb.key_in = 4'b0111;
        ticks(11);
        chk("long_press_evt", kb.key_press, 4'b1000);
`ifdef KEY_LONG_PRESS_EN
        exp_long = 1;
        ticks(39);
        chk("long_early", kb.long_press, 4'b0000);
        ticks(1);
        chk("long_pulse", kb.long_press, 4'b1000);
        ticks(1);
        chk("long_one_cycle", kb.long_press, 4'b0000);
        ticks(48);
`else
        exp_long = 0;
        ticks(89);
`endif
        kb.key_in = 4'b1111;
        ticks(14);
        chk_int("long_count", long_cnt[3] - base, exp_long);
        chk("long_released", kb.key_level, 4'b0000);

        // 30-cycle hold: too short for a long press
        base = long_cnt[3];
        kb.key_in = 4'b0111;
        ticks(30);
        kb.key_in = 4'b1111;
        ticks(20);
        chk_int("short_hold_no_long", long_cnt[3] - base, 0);
        chk("short_hold_level", kb.key_level, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side companion to the LED output drivers.
- Samples NUM_KEYS raw active-low push-buttons and synchronises them to clk (25 MHz board clock).
- Debounces each key with an independent per-key state machine.
- Outputs a clean pressed level plus one-cycle press/release pulses for downstream pattern and mode control logic.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYC, 500000: stable-input cycles required to accept a change (20 ms at 25 MHz); legal range 2 to 2^24-1.
- LONG_CYC, 25000000: held cycles before a long-press pulse (1 s at 25 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock, 25 MHz nominal.
- rst_n  in  1  asynchronous, active-low reset.
- key_in  in  NUM_KEYS  raw button inputs, active-low (0 = pressed), asynchronous to clk.
- key_level  out  NUM_KEYS  debounced state, active-high (1 = pressed).
- key_press  out  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  out  NUM_KEYS  one-cycle pulse on accepted release.
- long_press  out  NUM_KEYS  one-cycle pulse when held LONG_CYC cycles; constant 0 without the feature.

Behaviour:
- Reset is applied by rst_n, asynchronous, active-low, on clock clk.
- Reset values:
  - Synchroniser flops: all 1 (released).
  - All per-key states: IDLE.
  - All counters: 0.
  - key_level, key_press, key_release, long_press: all 0.
- Synchroniser: two flops per key; s2 is the synchronised input; s2 = 0 means pressed.
- Each key has its own debounce counter, width clog2(DEBOUNCE_CYC). Keys are fully independent; simultaneous events on several keys produce simultaneous pulses.
- State machine per key:
  - IDLE: key_level = 0. If s2 = 0, go to PDB and clear the counter.
  - PDB (press debounce):
    - If s2 = 1, go to IDLE with no output (bounce rejected).
    - Else if counter == DEBOUNCE_CYC-1, go to HELD, assert key_press for 1 cycle, and set key_level to 1 on the same edge.
    - Else increment the counter.
  - HELD: key_level = 1. If s2 = 1, go to RDB and clear the counter.
  - RDB (release debounce):
    - If s2 = 0, go to HELD with no output.
    - Else if counter == DEBOUNCE_CYC-1, go to IDLE, assert key_release for 1 cycle, and clear key_level on the same edge.
    - Else increment the counter.
- Latency: key_in goes low before edge 1 and stays low.
  - Edge 2: s2 = 0.
  - Edge 3: enter PDB with counter = 0.
  - Edge DEBOUNCE_CYC+3: key_press high for exactly one cycle and key_level = 1.
  - Release latency is identical.
- Bounces: any bounce shorter than DEBOUNCE_CYC cycles restarts qualification from the stable state and produces no pulse.
- key_level does not change during PDB or RDB.
- Counter never wraps; it is cleared on every state entry.
- Pulse exclusivity: key_press and key_release are never both high on one key in the same cycle.
- Reset mid-debounce or mid-hold:
  - Asynchronous return to IDLE with all outputs 0.
  - A key still held after reset deasserts is re-qualified as a new press (full latency, press pulse issued).
- All outputs are registered; no combinational path from key_in.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - Each key gets a hold counter, width clog2(LONG_CYC), cleared on entry to HELD.
  - The hold counter increments while in HELD and RDB, and saturates at LONG_CYC-1.
  - long_press pulses for one cycle on the edge where the count reaches LONG_CYC-1, i.e. LONG_CYC cycles after key_press.
  - At most one long_press per press; it is not re-armed until the key passes through IDLE.
  - A return from RDB to HELD does not clear the hold counter.
- Undefined: no hold counters are built; long_press is tied to 0.

Test Plan:
- Use DEBOUNCE_CYC=8, LONG_CYC=40, NUM_KEYS=4 for all scenarios.
- Clean press: key_in[0] driven 0 and held -> key_press[0] high exactly one cycle at edge 11 after the drive, key_level[0]=1; other keys silent.
- Bounce rejection: key_in[1] low 5 cycles, high 2, low 6, then high -> no key_press[1], key_level[1] stays 0. Then hold low 20 cycles -> single key_press 11 cycles after the final low.
- Release with chatter: key held, then key_in high 3 / low 1 / high stable -> key_release once, 11 cycles after the final rise; key_level drops on the same edge.
- Simultaneous keys: key_in = 4'b0000 on the same edge -> key_press = 4'b1111 in the same single cycle. Releasing all -> key_release = 4'b1111.
- Reset mid-operation: rst_n pulsed low while key 2 is in PDB (counter=4), key held throughout -> outputs 0 during reset; key_press[2] 11 cycles after rst_n rises.
- Long press (KEY_LONG_PRESS_EN): hold key 3 for 100 cycles -> long_press[3] exactly once, 40 cycles after key_press[3].
  - A 30-cycle hold gives no long_press.
  - A build without the macro gives long_press = 0 always.
